// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - architectural register file with per-register rename status
//
// Receives ROB commits and decode renames. Each register holds its committed value,
// a busy flag and the ROB tag of its youngest in-flight producer. Source lookups are
// combinational and see a same-cycle commit through a bypass path.

module reg_rename_file #(
  parameter int DATA_W    = 32,
  parameter int REG_IDX_W = 5,
  parameter int ROB_IDX_W = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clr_in,

  input  logic                 commit_valid,
  input  logic [REG_IDX_W-1:0] commit_rd,
  input  logic [ROB_IDX_W-1:0] commit_rob_index,
  input  logic [DATA_W-1:0]    commit_val,

  input  logic                 rename_valid,
  input  logic [REG_IDX_W-1:0] rename_rd,
  input  logic [ROB_IDX_W-1:0] rename_rob_index,

  input  logic [REG_IDX_W-1:0] rs1_index,
  input  logic [REG_IDX_W-1:0] rs2_index,

  output logic                 rs1_busy,
  output logic [ROB_IDX_W-1:0] rs1_tag,
  output logic [DATA_W-1:0]    rs1_val,
  output logic                 rs2_busy,
  output logic [ROB_IDX_W-1:0] rs2_tag,
  output logic [DATA_W-1:0]    rs2_val
);

  localparam int NUM_REGS = 1 << REG_IDX_W;

  logic [DATA_W-1:0]    val_q  [NUM_REGS];
  logic [DATA_W-1:0]    val_d  [NUM_REGS];
  logic [ROB_IDX_W-1:0] tag_q  [NUM_REGS];
  logic [ROB_IDX_W-1:0] tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_d;

  logic commit_fire;
  logic commit_current;
  logic rename_fire;

  // Qualify the commit and rename requests; the commit releases the rename only when
  // its tag is still the one recorded, otherwise a younger producer owns the register.
  always_comb begin
    commit_fire    = rdy_in && commit_valid && (commit_rd != '0);
    commit_current = busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_index);
    rename_fire    = rdy_in && rename_valid && (rename_rd != '0) && !clr_in;
  end

  // Next-state: commit writes the value, then flush or rename decides busy/tag.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;

    if (commit_fire) begin
      val_d[commit_rd] = commit_val;
      if (commit_current) begin
        busy_d[commit_rd] = 1'b0;
      end
    end

    if (rdy_in && clr_in) begin
      busy_d = '0;
    end else if (rename_fire) begin
      busy_d[rename_rd] = 1'b1;
      tag_d[rename_rd]  = rename_rob_index;
    end
  end

  // State registers; x0 is never selected by the next-state logic so it stays zero.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      busy_q <= busy_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // Source 1 lookup with same-cycle commit bypass; the same-cycle rename is not visible.
  always_comb begin
    rs1_busy = 1'b0;
    rs1_tag  = '0;
    rs1_val  = '0;
    if (rs1_index != '0) begin
      rs1_busy = busy_q[rs1_index];
      rs1_tag  = tag_q[rs1_index];
      rs1_val  = val_q[rs1_index];
      if (commit_fire && commit_current && (commit_rd == rs1_index)) begin
        rs1_busy = 1'b0;
        rs1_val  = commit_val;
      end
    end
  end

  // Source 2 lookup, identical to source 1.
  always_comb begin
    rs2_busy = 1'b0;
    rs2_tag  = '0;
    rs2_val  = '0;
    if (rs2_index != '0) begin
      rs2_busy = busy_q[rs2_index];
      rs2_tag  = tag_q[rs2_index];
      rs2_val  = val_q[rs2_index];
      if (commit_fire && commit_current && (commit_rd == rs2_index)) begin
        rs2_busy = 1'b0;
        rs2_val  = commit_val;
      end
    end
  end

endmodule
